pong_match_ctrl: RTL and testbench
==================================

// Module: pong_match_ctrl
// PURPOSE
//  Match sequencer for the two-paddle game. Owns the game FSM (idle/serve/play/point/over)
//  and the scores, and drives the paddle blocks' sync active-high reset and qualified up/down
//  strobes (one move per video frame, only while play is allowed). Drives ball reset/enable
//  and serve direction. Sits between the input buttons, the ball block and the two paddles.
// PARAMETERS
//  SCORE_MAX     7   points to win a match; legal range 1..15
//  SERVE_FRAMES  60  frame_tick count spent in SERVE before the ball is released; >=1
//  POINT_FRAMES  30  frame_tick count of the freeze after a point; >=1
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous reset, active-low
//  frame_tick     in   1  1-cycle pulse per video frame
//  start          in   1  start button, level; the block acts on its rising edge only
//  p1_up,p1_down  in   1  player-1 raw buttons, level
//  p2_up,p2_down  in   1  player-2 raw buttons, level
//  ball_out_l     in   1  1-cycle pulse: ball passed the left edge (P1 missed)
//  ball_out_r     in   1  1-cycle pulse: ball passed the right edge (P2 missed)
//  paddle_rst     out  1  sync active-high reset to both paddles (re-centres them)
//  p1_mv_up/dn    out  1  qualified 1-cycle move strobes to paddle 1
//  p2_mv_up/dn    out  1  qualified 1-cycle move strobes to paddle 2
//  ball_rst       out  1  holds ball at centre
//  ball_en        out  1  ball motion enable
//  serve_dir      out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
//  score1,score2  out  4  current scores
//  winner         out  2  00 none, 01 P1, 10 P2
//  state          out  3  FSM state for debug/display
// BEHAVIOUR
//  - All outputs are registered. On reset low (any time, incl. mid-match): state=IDLE,
//    scores=0, winner=00, serve_dir=1, paddle_rst=1, ball_rst=1, ball_en=0, strobes=0,
//    frame counter=0, start-edge detector primed to the current start level (no false start).
//  - IDLE: paddle_rst=1, ball_rst=1. Rising edge of start -> SERVE, scores cleared, serve_dir=1.
//  - SERVE: ball_rst=1, ball_en=0. Counter increments on each frame_tick; on the tick that
//    reaches SERVE_FRAMES -> PLAY, counter cleared. paddle_rst=1 only in the first SERVE cycle.
//  - PLAY: ball_en=1, ball_rst=0. ball_out_l: score2+1, serve_dir=0, -> POINT.
//    ball_out_r: score1+1, serve_dir=1, -> POINT. Both in the same cycle: no score change,
//    serve_dir unchanged, -> POINT.
//  - POINT: ball_en=0, ball_rst=0 (ball frozen in place), paddles frozen. After POINT_FRAMES
//    ticks: if score1==SCORE_MAX or score2==SCORE_MAX -> OVER, else -> SERVE.
//  - OVER: winner set on entry (01 or 10), ball_en=0, ball_rst=1; start rising edge -> IDLE
//    (scores and winner cleared on IDLE entry).
//  - Move strobes: in SERVE or PLAY only, on the cycle after frame_tick, pX_mv_up=1 iff
//    pX_up && !pX_down, pX_mv_dn=1 iff pX_down && !pX_up; both held -> none. Exactly one clk
//    cycle wide, so a paddle moves one delta per frame. A frame_tick in the same cycle as a
//    state change uses the pre-change state.
//  - Scores saturate at 15 (unreachable for legal SCORE_MAX but required). Counter width
//    is $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1); it is cleared on every state entry.
//  - ball_out pulses outside PLAY are ignored. start edges outside IDLE/OVER are ignored.
// STRUCTURE
//  - Shared package pong_pkg: state encodings (IDLE=0,SERVE=1,PLAY=2,POINT=3,OVER=4),
//    SCORE_W=4, winner codes; also used by the score display block.
//  - One sub-module: frame_timer (frame_tick counter with clear, done flag at N).
//  - Start edge detect, move-strobe qualifier and FSM live in this module.
// TESTING
//  1 reset low mid-PLAY with score 3-2 -> same cycle state=IDLE, scores 0-0, paddle_rst=1.
//  2 start rise in IDLE, SERVE_FRAMES=4 -> SERVE, paddle_rst 1 cycle, PLAY after 4th tick, ball_en=1.
//  3 PLAY, pulse ball_out_l -> score2=1, serve_dir=0, POINT; after POINT_FRAMES ticks -> SERVE.
//  4 ball_out_l and ball_out_r in one cycle -> scores unchanged, state POINT.
//  5 p1_up held 10 frames in PLAY -> exactly 10 one-cycle p1_mv_up; up+down held -> 0 strobes.
//  6 SCORE_MAX=2, P1 scores twice -> OVER, winner=01, strobes stay 0; start rise -> IDLE, 0-0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM state encoding, score
// width and saturation, winner codes. Also used by the score display block.
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam logic [SCORE_W-1:0] SCORE_SAT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    // Add one point, holding at the top of the score range.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_SAT) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_timer.sv
// Frame-tick counter used to time the SERVE and POINT phases. The count is
// cleared by the owner on every state entry; done fires combinationally on
// the tick that brings the count up to limit.
module frame_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Count ticks; clear has priority so a tick on a state change is not carried over.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick)
            count <= count + 1'b1;
    end

    // limit is at least 1, so limit-1 never wraps.
    assign done = tick && (count == limit - 1'b1);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the two-paddle game: game FSM, scores, paddle reset and
// per-frame move strobes, ball reset/enable and serve direction. All outputs
// are registered.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_MAX    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         p1_up,
    input  logic         p1_down,
    input  logic         p2_up,
    input  logic         p2_down,
    input  logic         ball_out_l,
    input  logic         ball_out_r,
    output logic         paddle_rst,
    output logic         p1_mv_up,
    output logic         p1_mv_dn,
    output logic         p2_mv_up,
    output logic         p2_mv_dn,
    output logic         ball_rst,
    output logic         ball_en,
    output logic         serve_dir,
    output logic [3:0]   score1,
    output logic [3:0]   score2,
    output logic [1:0]   winner,
    output logic [2:0]   state
);

    localparam int FRAMES_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(FRAMES_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LIM = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_LIM = CNT_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(SCORE_MAX);

    game_state_t         cur_st, nxt_st;
    logic [SCORE_W-1:0]  score1_q, score2_q, score1_nxt, score2_nxt;
    winner_t             winner_q, winner_nxt;
    logic                serve_dir_nxt;
    logic                start_q;
    logic                start_rise;
    logic                timer_clear, timer_tick, timer_done;
    logic [CNT_W-1:0]    timer_limit;
    logic [CNT_W-1:0]    timer_count;
    logic                move_ok;

    assign start_rise  = start && !start_q;
    assign timer_clear = (nxt_st != cur_st);
    assign timer_tick  = frame_tick && (cur_st == ST_SERVE || cur_st == ST_POINT);
    assign timer_limit = (cur_st == ST_SERVE) ? SERVE_LIM : POINT_LIM;
    assign move_ok     = frame_tick && (cur_st == ST_SERVE || cur_st == ST_PLAY);

    frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (timer_tick),
        .limit (timer_limit),
        .count (timer_count),
        .done  (timer_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur_st <= ST_IDLE;
        else
            cur_st <= nxt_st;
    end

    // Next state and next score/winner/serve-direction values.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        nxt_st        = cur_st;
        score1_nxt    = score1_q;
        score2_nxt    = score2_q;
        winner_nxt    = winner_q;
        serve_dir_nxt = serve_dir;
        unique case (cur_st)
            ST_IDLE: begin
                if (start_rise) begin
                    nxt_st        = ST_SERVE;
                    score1_nxt    = '0;
                    score2_nxt    = '0;
                    serve_dir_nxt = 1'b1;
                end
            end
            ST_SERVE: begin
                if (timer_done)
                    nxt_st = ST_PLAY;
            end
            ST_PLAY: begin
                if (ball_out_l && ball_out_r) begin
                    nxt_st = ST_POINT;
                end else if (ball_out_l) begin
                    nxt_st        = ST_POINT;
                    score2_nxt    = score_inc(score2_q);
                    serve_dir_nxt = 1'b0;
                end else if (ball_out_r) begin
                    nxt_st        = ST_POINT;
                    score1_nxt    = score_inc(score1_q);
                    serve_dir_nxt = 1'b1;
                end
            end
            ST_POINT: begin
                if (timer_done) begin
                    if (score1_q == WIN_SCORE || score2_q == WIN_SCORE) begin
                        nxt_st     = ST_OVER;
                        winner_nxt = (score1_q == WIN_SCORE) ? WIN_P1 : WIN_P2;
                    end else begin
                        nxt_st = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    nxt_st     = ST_IDLE;
                    score1_nxt = '0;
                    score2_nxt = '0;
                    winner_nxt = WIN_NONE;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    // Registered outputs, derived from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score1_q   <= '0;
            score2_q   <= '0;
            winner_q   <= WIN_NONE;
            serve_dir  <= 1'b1;
            paddle_rst <= 1'b1;
            ball_rst   <= 1'b1;
            ball_en    <= 1'b0;
            p1_mv_up   <= 1'b0;
            p1_mv_dn   <= 1'b0;
            p2_mv_up   <= 1'b0;
            p2_mv_dn   <= 1'b0;
            // Treat start as held until it is seen low, so a button held through reset is not a start.
            start_q    <= 1'b1;
        end else begin
            score1_q   <= score1_nxt;
            score2_q   <= score2_nxt;
            winner_q   <= winner_nxt;
            serve_dir  <= serve_dir_nxt;
            paddle_rst <= (nxt_st == ST_IDLE) || (nxt_st == ST_SERVE && cur_st != ST_SERVE);
            ball_rst   <= (nxt_st == ST_IDLE) || (nxt_st == ST_SERVE) || (nxt_st == ST_OVER);
            ball_en    <= (nxt_st == ST_PLAY);
            p1_mv_up   <= move_ok && p1_up && !p1_down;
            p1_mv_dn   <= move_ok && p1_down && !p1_up;
            p2_mv_up   <= move_ok && p2_up && !p2_down;
            p2_mv_dn   <= move_ok && p2_down && !p2_up;
            start_q    <= start;
        end
    end

    assign score1 = score1_q;
    assign score2 = score2_q;
    assign winner = winner_q;
    assign state  = cur_st;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised bench for pong_match_ctrl. A driver applies inputs on the falling
// edge and pushes the game model's expected outputs into a queue; a monitor
// pops and compares just after each rising edge.
module tb_pong_match_ctrl;

    localparam int SMAX   = 4;
    localparam int SF     = 4;
    localparam int PF     = 3;
    localparam int NCYC   = 6000;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0, start = 1'b0;
    logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic ball_out_l = 1'b0, ball_out_r = 1'b0;
    logic paddle_rst, p1_mv_up, p1_mv_dn, p2_mv_up, p2_mv_dn;
    logic ball_rst, ball_en, serve_dir;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    pong_match_ctrl #(
        .SCORE_MAX    (SMAX),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .ball_out_l (ball_out_l),
        .ball_out_r (ball_out_r),
        .paddle_rst (paddle_rst),
        .p1_mv_up   (p1_mv_up),
        .p1_mv_dn   (p1_mv_dn),
        .p2_mv_up   (p2_mv_up),
        .p2_mv_dn   (p2_mv_dn),
        .ball_rst   (ball_rst),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
        logic       dir;
        logic       prst;
        logic       brst;
        logic       ben;
        logic       u1;
        logic       d1;
        logic       u2;
        logic       d2;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cyc = 0;

    // Game model: phase, scores, serve direction, winner, frames spent in the phase.
    int   m_phase = P_IDLE;
    int   m_s1 = 0, m_s2 = 0, m_win = 0, m_frames = 0;
    bit   m_dir = 1'b1;
    bit   m_prev_start = 1'b0;
    int   over_seen = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state;   o.s1 = score1;  o.s2 = score2;  o.win = winner;
        o.dir = serve_dir; o.prst = paddle_rst; o.brst = ball_rst; o.ben = ball_en;
        o.u1 = p1_mv_up; o.d1 = p1_mv_dn; o.u2 = p2_mv_up; o.d2 = p2_mv_dn;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.dir  = 1'b1;
        o.prst = 1'b1;
        o.brst = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d s=%0d-%0d win=%0d dir=%b prst=%b brst=%b ben=%b mv=%b%b%b%b, expected st=%0d s=%0d-%0d win=%0d dir=%b prst=%b brst=%b ben=%b mv=%b%b%b%b",
                     name, act.st, act.s1, act.s2, act.win, act.dir, act.prst, act.brst, act.ben,
                     act.u1, act.d1, act.u2, act.d2,
                     exp.st, exp.s1, exp.s2, exp.win, exp.dir, exp.prst, exp.brst, exp.ben,
                     exp.u1, exp.d1, exp.u2, exp.d2);
        end
    endtask

    // Advance the game model by one clock using the inputs now on the pins.
    task automatic model_step();
        obs_t o;
        bit   rise, mv;
        int   old;
        o = '0;
        if (!reset) begin
            m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b1; m_frames = 0;
            m_prev_start = start;
            o = reset_obs();
        end else begin
            rise = start && !m_prev_start;
            m_prev_start = start;
            old = m_phase;
            mv = frame_tick && (old == P_SERVE || old == P_PLAY);
            o.u1 = mv && p1_up && !p1_down;
            o.d1 = mv && p1_down && !p1_up;
            o.u2 = mv && p2_up && !p2_down;
            o.d2 = mv && p2_down && !p2_up;
            case (old)
                P_IDLE: if (rise) begin
                    m_phase = P_SERVE; m_s1 = 0; m_s2 = 0; m_dir = 1'b1;
                end
                P_SERVE: if (frame_tick) begin
                    m_frames++;
                    if (m_frames == SF) m_phase = P_PLAY;
                end
                P_PLAY: begin
                    if (ball_out_l && ball_out_r) begin
                        m_phase = P_POINT;
                    end else if (ball_out_l) begin
                        m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dir = 1'b0; m_phase = P_POINT;
                    end else if (ball_out_r) begin
                        m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dir = 1'b1; m_phase = P_POINT;
                    end
                end
                P_POINT: if (frame_tick) begin
                    m_frames++;
                    if (m_frames == PF) begin
                        if (m_s1 == SMAX || m_s2 == SMAX) begin
                            m_phase = P_OVER;
                            m_win = (m_s1 == SMAX) ? 1 : 2;
                            over_seen++;
                        end else begin
                            m_phase = P_SERVE;
                        end
                    end
                end
                default: if (rise) begin
                    m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
                end
            endcase
            if (m_phase != old) m_frames = 0;
            o.st   = 3'(m_phase);
            o.s1   = 4'(m_s1);
            o.s2   = 4'(m_s2);
            o.win  = 2'(m_win);
            o.dir  = m_dir;
            o.prst = (m_phase == P_IDLE) || (m_phase == P_SERVE && old != P_SERVE);
            o.brst = (m_phase == P_IDLE) || (m_phase == P_SERVE) || (m_phase == P_OVER);
            o.ben  = (m_phase == P_PLAY);
        end
        exp_q.push_back(o);
    endtask

    // Monitor: compare the DUT against the oldest expectation after each rising edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d", mon_cyc), sample(), e);
                mon_cyc++;
            end
        end
    end

    // Driver: random inputs, occasional mid-match resets, model update per cycle.
    initial begin
        int  rst_left;
        int  mid_resets;
        bit  last_reset;
        int  r;
        rst_left   = 0;
        mid_resets = 0;
        last_reset = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (reset && mid_resets < 3 && cyc > 300 + 1500 * mid_resets &&
                m_phase == P_PLAY && (m_s1 + m_s2) >= 2) begin
                rst_left = 2;
                mid_resets++;
            end
            reset = !(cyc < 3 || rst_left > 0);
            if (rst_left > 0) rst_left--;

            frame_tick = ($urandom_range(0, 2) == 0);
            // start only moves while reset is high and was high last cycle, so it is
            // stable through reset release.
            if (reset && last_reset && $urandom_range(0, 9) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) p1_up   = ~p1_up;
            if ($urandom_range(0, 7) == 0) p1_down = ~p1_down;
            if ($urandom_range(0, 7) == 0) p2_up   = ~p2_up;
            if ($urandom_range(0, 7) == 0) p2_down = ~p2_down;
            r = $urandom_range(0, 29);
            ball_out_l = (r < 2) || (r == 5);
            ball_out_r = (r == 2) || (r == 3) || (r == 5);

            if (last_reset && !reset) begin
                #1;
                check("async_reset", sample(), reset_obs());
            end
            model_step();
            last_reset = reset;
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        checks++;
        if (over_seen == 0) begin
            errors++;
            $display("FAIL match_end: got %0d completed matches, expected at least 1", over_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
